meas_seq_ctrl: RTL and testbench

Parametrised measurement sequencer that replaces the single-shot key-driven Tx/Re controller.
- Debounces the start/stop key and runs a programmable burst of TX→RE measurement cycles, with an optional gap between cycles.
- Supports continuous mode, key abort mid-burst, and a per-phase timeout watchdog with a sticky error state.
- Sits between the board key/LED and the transmitter/receiver blocks, in the clk_100 domain.

---
 rtl/meas_pkg.sv | 22 ++
 rtl/key_debounce.sv | 39 +++
 rtl/meas_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_meas_seq_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared state encodings and default constants for the
// measurement sequencer and its key debouncer.
package meas_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_TX   = 5'b00010,
    ST_RE   = 5'b00100,
    ST_GAP  = 5'b01000,
    ST_ERR  = 5'b10000
  } state_e;

  localparam int unsigned IDLE_B = 0;
  localparam int unsigned TX_B   = 1;
  localparam int unsigned RE_B   = 2;
  localparam int unsigned GAP_B  = 3;
  localparam int unsigned ERR_B  = 4;

  localparam int unsigned DEB_CNT_DEF = 1_000_000;
  localparam logic [23:0] TIMEOUT_DEF = 24'd10_000_000;

endpackage

// File: rtl/key_debounce.sv
// Slow-samples an active-low key and emits one pulse per press.
// The pulse is combinational from the two sample registers.
module key_debounce
  import meas_pkg::*;
#(
  parameter int unsigned DEB_CNT = DEB_CNT_DEF,
  parameter int unsigned DEB_W   = 20
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic key_in,
  output logic key_evt
);

  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             key_s_q, key_s_d;
  logic             key_s_r_q;
  logic             wrap;

  assign wrap    = (cnt_q == DEB_W'(DEB_CNT - 1));
  assign cnt_d   = wrap ? '0 : cnt_q + DEB_W'(1);
  assign key_s_d = wrap ? key_in : key_s_q;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      key_s_q   <= 1'b1;
      key_s_r_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      key_s_q   <= key_s_d;
      key_s_r_q <= key_s_q;
    end
  end

  // Falling edge of the sampled key, seen for one cycle only.
  assign key_evt = key_s_r_q & ~key_s_q;

endmodule

// File: rtl/meas_seq_ctrl.sv
// Key-started burst sequencer driving TX/RE enables with
// optional inter-cycle gap and a per-phase watchdog.
module meas_seq_ctrl
  import meas_pkg::*;
#(
  parameter int unsigned     DEB_CNT = DEB_CNT_DEF,
  parameter int unsigned     DEB_W   = 20,
  parameter int unsigned     BURST_W = 8,
  parameter int unsigned     GAP_W   = 16,
  parameter int unsigned     TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(TIMEOUT_DEF)
) (
  input  logic               clk_100,
  input  logic               rst_n,
  input  logic               key_in,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic               overTx,
  input  logic               overRe,
  output logic               enTx,
  output logic               enRe,
  output logic               busy,
  output logic               run_led,
  output logic               err_timeout,
  output logic               burst_done,
  output logic [BURST_W-1:0] cycle_cnt
);

  state_e             state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               bd_q, bd_d;
  logic               key_evt;
  logic               wd_exp;
  logic               gap_end;

  key_debounce #(
    .DEB_CNT (DEB_CNT),
    .DEB_W   (DEB_W)
  ) u_deb (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .key_in  (key_in),
    .key_evt (key_evt)
  );

  assign wd_exp  = (TIMEOUT != '0) &&
                   (wd_q == TIMEOUT - TO_W'(1));
  assign gap_end = (gcnt_q == '0);

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    bd_d    = 1'b0;
    unique case (1'b1)
      state_q[IDLE_B]: begin
        if (key_evt) begin
          burst_d = cfg_burst;
          gap_d   = cfg_gap;
          cnt_d   = '0;
          state_d = ST_TX;
        end
      end
      state_q[TX_B]: begin
        if (key_evt)     state_d = ST_IDLE;
        else if (wd_exp) state_d = ST_ERR;
        else if (overTx) state_d = ST_RE;
      end
      state_q[RE_B]: begin
        if (key_evt)     state_d = ST_IDLE;
        else if (wd_exp) state_d = ST_ERR;
        else if (overRe) begin
          cnt_d = cnt_q + BURST_W'(1);
          if ((burst_q != '0) && (cnt_d == burst_q)) begin
            state_d = ST_IDLE;
            bd_d    = 1'b1;
          end else if (gap_q == '0) begin
            state_d = ST_TX;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      state_q[GAP_B]: begin
        if (key_evt)      state_d = ST_IDLE;
        else if (gap_end) state_d = ST_TX;
      end
      state_q[ERR_B]: begin
        if (key_evt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gap counter loads gap-1 on entry so the phase lasts gap cycles.
  always_comb begin
    gcnt_d = gcnt_q;
    if (state_d[GAP_B] && !state_q[GAP_B])
      gcnt_d = gap_q - GAP_W'(1);
    else if (state_q[GAP_B] && !gap_end)
      gcnt_d = gcnt_q - GAP_W'(1);
  end

  always_comb begin
    wd_d = wd_q;
    if ((state_d[TX_B] && !state_q[TX_B]) ||
        (state_d[RE_B] && !state_q[RE_B]))
      wd_d = '0;
    else if (state_q[TX_B] || state_q[RE_B])
      wd_d = wd_q + TO_W'(1);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      wd_q    <= '0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      wd_q    <= wd_d;
      bd_q    <= bd_d;
    end
  end

  assign enTx        = state_q[TX_B];
  assign enRe        = state_q[RE_B];
  assign busy        = state_q[TX_B] | state_q[RE_B] |
                       state_q[GAP_B];
  assign run_led     = ~busy;
  assign err_timeout = state_q[ERR_B];
  assign burst_done  = bd_q;
  assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Scoreboard bench: a phase-level model predicts every output
// cycle; a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_meas_seq_ctrl;

  localparam int DEB = 6;
  localparam int TMO = 50;
  localparam int BW  = 8;
  localparam int GW  = 16;

  logic          clk_100 = 1'b0;
  logic          rst_n   = 1'b0;
  logic          key_in  = 1'b1;
  logic          overTx  = 1'b0;
  logic          overRe  = 1'b0;
  logic [BW-1:0] cfg_burst = '0;
  logic [GW-1:0] cfg_gap   = '0;
  logic          enTx, enRe, busy, run_led;
  logic          err_timeout, burst_done;
  logic [BW-1:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  meas_seq_ctrl #(
    .DEB_CNT (DEB),
    .DEB_W   (3),
    .BURST_W (BW),
    .GAP_W   (GW),
    .TO_W    (24),
    .TIMEOUT (24'd50)
  ) dut (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .cfg_burst   (cfg_burst),
    .cfg_gap     (cfg_gap),
    .overTx      (overTx),
    .overRe      (overRe),
    .enTx        (enTx),
    .enRe        (enRe),
    .busy        (busy),
    .run_led     (run_led),
    .err_timeout (err_timeout),
    .burst_done  (burst_done),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct packed {
    logic          tx, re, bsy, led, err, bd;
    logic [BW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_TX, P_RE, P_GAP, P_ERR} ph_t;
  ph_t ph;
  int  tin, edges, burst, gap, done;
  bit  samp, evt_nxt, bd;

  task automatic m_reset();
    ph = P_IDLE; tin = 0; edges = 0;
    burst = 0; gap = 0; done = 0;
    samp = 1; evt_nxt = 0; bd = 0;
  endtask

  task automatic m_step();
    bit  evt;
    ph_t nx;
    evt = evt_nxt;
    evt_nxt = 0;
    edges++;
    if (edges % DEB == 0) begin
      evt_nxt = samp && !key_in;
      samp = key_in;
    end
    nx = ph;
    bd = 0;
    case (ph)
      P_IDLE: if (evt) begin
        burst = cfg_burst; gap = cfg_gap; done = 0; nx = P_TX;
      end
      P_TX: begin
        if (evt) nx = P_IDLE;
        else if (TMO != 0 && tin + 1 == TMO) nx = P_ERR;
        else if (overTx) nx = P_RE;
      end
      P_RE: begin
        if (evt) nx = P_IDLE;
        else if (TMO != 0 && tin + 1 == TMO) nx = P_ERR;
        else if (overRe) begin
          done = (done + 1) % (1 << BW);
          if (burst != 0 && done == burst) begin
            nx = P_IDLE; bd = 1;
          end else nx = (gap == 0) ? P_TX : P_GAP;
        end
      end
      P_GAP: begin
        if (evt) nx = P_IDLE;
        else if (tin + 1 >= gap) nx = P_TX;
      end
      P_ERR: if (evt) nx = P_IDLE;
      default: nx = P_IDLE;
    endcase
    tin = (nx == ph) ? tin + 1 : 0;
    ph = nx;
  endtask

  function automatic obs_t m_obs();
    obs_t o;
    o.tx  = (ph == P_TX);
    o.re  = (ph == P_RE);
    o.bsy = ph inside {P_TX, P_RE, P_GAP};
    o.led = !o.bsy;
    o.err = (ph == P_ERR);
    o.bd  = bd;
    o.cnt = BW'(done);
    return o;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk_100 or negedge rst_n);
      if (!rst_n) begin
        m_reset();
        exp_q.delete();
      end else begin
        m_step();
        exp_q.push_back(m_obs());
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    obs_t e, a;
    @(negedge clk_100);
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {enTx, enRe, busy, run_led, err_timeout,
           burst_done, cycle_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle t=%0t got=%b want=%b",
                 $time, a, e);
      end
    end
  end

  int   ntx_rise = 0, nbd = 0, ntx_hi = 0, b2b = 0;
  logic ctx = 0, cre = 0;
  initial forever begin
    @(negedge clk_100);
    if (enTx && !ctx) ntx_rise++;
    if (burst_done) nbd++;
    if (enTx) ntx_hi++;
    if (enTx && cre) b2b++;
    ctx = enTx;
    cre = enRe;
  end

  // ---------------- TX/RE responder ----------------
  int   tx_dly = 10, re_dly = 8, ttx = 0, tre = 0;
  bit   lvl = 0, nz = 0;
  logic ptx = 0, pre = 0;
  initial forever begin
    @(negedge clk_100);
    ttx = (enTx && !ptx) ? 0 : ttx + 1;
    tre = (enRe && !pre) ? 0 : tre + 1;
    ptx = enTx;
    pre = enRe;
    overTx = lvl || (enTx && ttx == tx_dly) ||
             (nz && $urandom_range(0, 9) == 0);
    overRe = lvl || (enRe && tre == re_dly) ||
             (nz && $urandom_range(0, 9) == 0);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk_100);
    #1;
  endtask

  task automatic chk(input string nm, input longint act,
                     input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  task automatic wait_for(input string nm, input int sel,
                          input int bound);
    bit hit;
    hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      tick();
      case (sel)
        0: hit = !busy;
        1: hit = enRe;
        2: hit = enTx;
        3: hit = err_timeout;
        default: hit = !enRe;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: not seen in %0d cycles", nm, bound);
    end
  endtask

  task automatic press(input int hold);
    key_in = 0;
    repeat (hold) tick();
    key_in = 1;
    repeat (2 * DEB + 2) tick();
  endtask

  task automatic setup(input int b, input int g,
                       input int td, input int rd);
    cfg_burst = BW'(b);
    cfg_gap   = GW'(g);
    tx_dly    = td;
    re_dly    = rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r0, b0, h0, q0;
    #23;
    chk("rst_enTx", enTx, 0);
    chk("rst_enRe", enRe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_led", run_led, 1);
    chk("rst_err", err_timeout, 0);
    chk("rst_bd", burst_done, 0);
    chk("rst_cnt", cycle_cnt, 0);
    tick();
    rst_n = 1;
    repeat (10) tick();

    // single burst
    setup(3, 4, 10, 8);
    r0 = ntx_rise; b0 = nbd;
    press(12);
    wait_for("burst", 0, 400);
    chk("burst_tx_pairs", ntx_rise - r0, 3);
    chk("burst_done_cnt", nbd - b0, 1);
    chk("burst_cycle_cnt", cycle_cnt, 3);
    chk("burst_busy", busy, 0);
    chk("burst_led", run_led, 1);

    // abort in second RE
    setup(0, 4, 10, 40);
    press(12);
    wait_for("re1", 1, 100);
    wait_for("re1_end", 4, 100);
    wait_for("re2", 1, 100);
    b0 = nbd;
    press(12);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", cycle_cnt, 1);
    chk("abort_no_bd", nbd - b0, 0);

    // watchdog timeout
    setup(2, 3, -1, 8);
    h0 = ntx_hi;
    press(12);
    wait_for("err", 3, 150);
    chk("to_tx_len", ntx_hi - h0, TMO);
    chk("to_enTx", enTx, 0);
    chk("to_err", err_timeout, 1);
    press(12);
    chk("clr_err", err_timeout, 0);
    chk("clr_enTx", enTx, 0);
    chk("clr_busy", busy, 0);
    press(12);
    chk("restart_enTx", enTx, 1);
    wait_for("err2", 3, 150);
    press(12);
    chk("clr2_err", err_timeout, 0);

    // bouncing key gives one start
    setup(0, 2, 5, 5);
    key_in = 0; tick();
    key_in = 1; tick();
    key_in = 0; tick();
    repeat (40) tick();
    key_in = 1;
    repeat (14) tick();
    chk("bounce_busy", busy, 1);
    press(12);
    chk("bounce_stop", busy, 0);
    // short pulse between samples
    do tick(); while (edges % DEB != 0);
    key_in = 0;
    repeat (3) tick();
    key_in = 1;
    repeat (20) tick();
    chk("short_pulse", busy, 0);

    // key event and overRe together
    setup(0, 3, 4, -1);
    press(12);
    chk("simul_in_re", enRe, 1);
    do tick(); while (edges % DEB != DEB - 1);
    key_in = 0;
    tick();
    overRe = 1;
    repeat (10) tick();
    key_in = 1;
    repeat (14) tick();
    chk("simul_busy", busy, 0);
    chk("simul_cnt", cycle_cnt, 0);

    // zero gap: RE goes straight to TX
    setup(2, 0, 3, 3);
    q0 = b2b; b0 = nbd;
    press(12);
    wait_for("gap0", 0, 200);
    chk("gap0_b2b", b2b - q0, 1);
    chk("gap0_bd", nbd - b0, 1);
    chk("gap0_cnt", cycle_cnt, 2);

    // asynchronous reset during TX
    setup(0, 2, 10, 8);
    press(12);
    wait_for("rst_re", 1, 60);
    wait_for("rst_tx", 2, 60);
    #3;
    rst_n = 0;
    #1;
    chk("arst_enTx", enTx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_led", run_led, 1);
    chk("arst_cnt", cycle_cnt, 0);
    repeat (2) tick();
    rst_n = 1;
    r0 = ntx_rise;
    repeat (40) tick();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_no_tx", ntx_rise - r0, 0);

    // continuous wrap of cycle_cnt
    setup(0, 0, -1, -1);
    lvl = 1;
    press(12);
    repeat (560) tick();
    press(12);
    lvl = 0;
    chk("wrap_stop", busy, 0);

    // randomized bursts with config churn and noise
    for (int it = 0; it < 10; it++) begin
      int b;
      b = $urandom_range(0, 4);
      setup(b, $urandom_range(0, 5), $urandom_range(0, 12),
            $urandom_range(0, 12));
      nz = 1;
      press($urandom_range(DEB, 2 * DEB));
      cfg_burst = BW'($urandom);
      cfg_gap   = GW'($urandom_range(0, 7));
      if (b == 0) begin
        repeat ($urandom_range(5, 120)) tick();
        press($urandom_range(DEB, 2 * DEB));
      end
      wait_for("rand", 0, 3000);
      nz = 0;
      repeat (3) tick();
    end

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
